systolic_array_os: RTL and testbench

- Parametrised N x N output-stationary systolic matrix-multiply array; successor to the fixed 2x2 PE grid.
- Computes C = A x B, with A N x K and B K x N. Each K-step presents one column of A and one row of B.
- Adds features the 2x2 grid lacks: internal input skewing, beat-level valid tracking, a start/done command handshake with run length K, and a row-serial result drain with ready backpressure.

---
 rtl/systolic_array_os.sv | 225 ++++++++++++++++++++++
 tb/tb_systolic_array_os.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_os.sv
// N x N output-stationary systolic matrix multiplier computing C = A x B.
// Operands are skewed internally, and result rows are drained one at a time under res_ready.
module systolic_array_os #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned N      = 4,
  parameter int unsigned K_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  output logic                   busy,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [N*DATA_W-1:0]    a_in,
  input  logic [N*DATA_W-1:0]    b_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(N)-1:0]   res_row,
  output logic [N*ACC_W-1:0]     res_out,
  output logic                   done
);

  localparam int unsigned RowW = $clog2(N);
  localparam int unsigned FlW  = $clog2(2 * N);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  k_len_q, k_len_d;
  logic [K_W-1:0]  k_cnt_q, k_cnt_d;
  logic [FlW-1:0]  fl_cnt_q, fl_cnt_d;
  logic [RowW-1:0] row_q, row_d;
  logic            done_q, done_d;
  logic            beat, clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      fl_cnt_q <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      k_cnt_q  <= k_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    k_cnt_d  = k_cnt_q;
    fl_cnt_d = fl_cnt_q;
    row_d    = row_q;
    done_d   = 1'b0;
    beat     = 1'b0;
    clr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_len_d = k_len;
          k_cnt_d = '0;
          clr     = 1'b1;
          state_d = (k_len == '0) ? StDrain : StLoad;
        end
      end
      StLoad: begin
        if (a_valid) begin
          beat    = 1'b1;
          k_cnt_d = k_cnt_q + K_W'(1);
          if (k_cnt_q + K_W'(1) == k_len_q) begin
            state_d  = StFlush;
            fl_cnt_d = '0;
          end
        end
      end
      StFlush: begin
        // 2N-1 cycles: enough for the last beat to reach PE(N-1,N-1).
        if (fl_cnt_q == FlW'(2 * N - 2)) state_d = StDrain;
        else                             fl_cnt_d = fl_cnt_q + FlW'(1);
      end
      StDrain: begin
        if (res_ready) begin
          if (row_q == RowW'(N - 1)) begin
            state_d = StIdle;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign a_ready   = (state_q == StLoad);
  assign res_valid = (state_q == StDrain);
  assign res_row   = row_q;
  assign done      = done_q;

  // Skewed operands entering the left column / top row.
  logic [DATA_W-1:0] a_sk [N];
  logic [DATA_W-1:0] b_sk [N];
  logic              av_sk [N];
  logic              bv_sk [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_sk[i]  = a_in[0 +: DATA_W];
      assign b_sk[i]  = b_in[0 +: DATA_W];
      assign av_sk[i] = beat;
      assign bv_sk[i] = beat;
    end else begin : g_delay
      logic [DATA_W-1:0] sa_q [i];
      logic [DATA_W-1:0] sb_q [i];
      logic              sav_q [i];
      logic              sbv_q [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s]  <= '0;
            sb_q[s]  <= '0;
            sav_q[s] <= 1'b0;
            sbv_q[s] <= 1'b0;
          end
        end else begin
          sa_q[0]  <= a_in[i*DATA_W +: DATA_W];
          sb_q[0]  <= b_in[i*DATA_W +: DATA_W];
          sav_q[0] <= beat;
          sbv_q[0] <= beat;
          for (int s = 1; s < i; s++) begin
            sa_q[s]  <= sa_q[s-1];
            sb_q[s]  <= sb_q[s-1];
            sav_q[s] <= sav_q[s-1];
            sbv_q[s] <= sbv_q[s-1];
          end
        end
      end
      assign a_sk[i]  = sa_q[i-1];
      assign b_sk[i]  = sb_q[i-1];
      assign av_sk[i] = sav_q[i-1];
      assign bv_sk[i] = sbv_q[i-1];
    end
  end

  // Forwarded operands; the last column/row has no consumer so holds no register.
  logic [DATA_W-1:0] pa_q  [N][N-1];
  logic              pav_q [N][N-1];
  logic [DATA_W-1:0] pb_q  [N-1][N];
  logic              pbv_q [N-1][N];
  logic [ACC_W-1:0]  acc_q [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DATA_W-1:0]       a_l, b_t;
      logic                    av_l, bv_t;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    prod_ext;

      if (j == 0) begin : g_a_edge
        assign a_l  = a_sk[i];
        assign av_l = av_sk[i];
      end else begin : g_a_inner
        assign a_l  = pa_q[i][j-1];
        assign av_l = pav_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_t  = b_sk[j];
        assign bv_t = bv_sk[j];
      end else begin : g_b_inner
        assign b_t  = pb_q[i-1][j];
        assign bv_t = pbv_q[i-1][j];
      end

      assign prod     = $signed(a_l) * $signed(b_t);
      assign prod_ext = prod;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)              acc_q[i][j] <= '0;
        else if (clr)          acc_q[i][j] <= '0;
        else if (av_l && bv_t) acc_q[i][j] <= acc_q[i][j] + $unsigned(prod_ext);
      end

      if (j < N - 1) begin : g_pass_a
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            pa_q[i][j]  <= '0;
            pav_q[i][j] <= 1'b0;
          end else begin
            pa_q[i][j]  <= a_l;
            pav_q[i][j] <= av_l;
          end
        end
      end
      if (i < N - 1) begin : g_pass_b
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            pb_q[i][j]  <= '0;
            pbv_q[i][j] <= 1'b0;
          end else begin
            pb_q[i][j]  <= b_t;
            pbv_q[i][j] <= bv_t;
          end
        end
      end
    end
  end

  always_comb begin
    res_out = '0;
    if (state_q == StDrain) begin
      for (int j = 0; j < N; j++) res_out[j*ACC_W +: ACC_W] = acc_q[row_q][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os (N=4, ACC_W=32): identity, signed with bubbles and
// backpressure, wrap-around, k_len=0, and reset abort followed by a fresh job.
module tb_systolic_array_os;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KW   = 10;
  localparam int KMAX = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              busy;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [N*DW-1:0]   a_in = '0;
  logic [N*DW-1:0]   b_in = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [1:0]        res_row;
  logic [N*AW-1:0]   res_out;
  logic              done;

  systolic_array_os #(.DATA_W(DW), .ACC_W(AW), .N(N), .K_W(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_row   (res_row),
    .res_out   (res_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int am [N][KMAX];
  int bm [KMAX][N];
  logic [AW-1:0] ec [N][N];

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input int k);
    longint s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int t = 0; t < k; t++) s += longint'(am[i][t]) * longint'(bm[t][j]);
        ec[i][j] = AW'(s);
      end
    end
  endtask

  task automatic fill_ec(input logic [AW-1:0] v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ec[i][j] = v;
  endtask

  task automatic run_job(input int k, input int nbeats, input bit bubbles);
    int t;
    int cyc;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    t = 0;
    cyc = 0;
    while (t < nbeats) begin
      if (bubbles && (cyc % 3 == 1)) begin
        a_valid = 1'b0;
      end else begin
        a_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          a_in[i*DW +: DW] = DW'(am[i][t]);
          b_in[i*DW +: DW] = DW'(bm[t][i]);
        end
        t++;
      end
      cyc++;
      @(negedge clk);
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_res_valid();
    int w;
    w = 0;
    while (!res_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("res_valid_wait", res_valid, 1);
  endtask

  task automatic chk_row(input int r, input string tag);
    chk({tag, "_row"}, res_row, r);
    for (int j = 0; j < N; j++)
      chk($sformatf("%s_c%0d%0d", tag, r, j), res_out[j*AW +: AW], ec[r][j]);
  endtask

  task automatic drain(input int hold);
    for (int r = 0; r < N; r++) begin
      wait_res_valid();
      if (!res_valid) return;
      chk_row(r, "drain");
      if (hold > 0) begin
        res_ready = 1'b0;
        repeat (hold) begin
          @(negedge clk);
          chk("hold_valid", res_valid, 1);
          chk_row(r, "hold");
        end
      end
      res_ready = 1'b1;
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("valid_after", res_valid, 0);
    chk("busy_after", busy, 0);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_row", res_row, 0);
    chk("rst_done", done, 0);
    for (int j = 0; j < N; j++) chk("rst_res_out", res_out[j*AW +: AW], 0);
    rst = 1'b1;

    // a_valid in IDLE changes nothing.
    @(negedge clk);
    a_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_avalid_busy", busy, 0);
    chk("idle_avalid_ready", a_ready, 0);
    a_valid = 1'b0;

    // Identity B: C equals A.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = i * 10 + k + 1;
        bm[k][i] = 0;
      end
    for (int k = 0; k < N; k++) bm[k][k] = 1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ec[i][j] = AW'(i * 10 + j + 1);
    run_job(4, 4, 1'b0);
    chk("load_done_busy", busy, 1);
    drain(0);

    // Signed operands with bubbles and 5-cycle backpressure per row.
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < N; i++) begin
        am[i][k] = (i + 1) * (k - 3) * 100 - 7;
        bm[k][i] = (i - 1) * (k + 2) * -57 + 5;
      end
    model(6);
    run_job(6, 6, 1'b1);
    drain(5);

    // Wrap-around: (-32768)^2 = 2^30; four of them wrap to 0, three give 0xC0000000.
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        am[i][k] = -32768;
        bm[k][i] = -32768;
      end
    fill_ec(32'h0000_0000);
    run_job(4, 4, 1'b0);
    drain(0);
    fill_ec(32'hC000_0000);
    run_job(3, 3, 1'b0);
    drain(0);

    // k_len = 0 skips LOAD and drains zeros.
    fill_ec(32'h0);
    run_job(0, 0, 1'b0);
    chk("k0_no_load", a_ready, 0);
    drain(0);

    // Reset mid-LOAD abandons the job.
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        am[i][k] = 1000;
        bm[k][i] = 1000;
      end
    run_job(4, 2, 1'b0);
    chk("midload_ready", a_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    rst = 1'b1;

    // Fresh K=1 job of all 2s; start during DRAIN is ignored.
    for (int i = 0; i < N; i++) begin
      am[i][0] = 2;
      bm[0][i] = 2;
    end
    fill_ec(32'd4);
    run_job(1, 1, 1'b0);
    wait_res_valid();
    start = 1'b1;
    k_len = KW'(5);
    @(negedge clk);
    start = 1'b0;
    chk("drain_start_valid", res_valid, 1);
    chk("drain_start_row", res_row, 0);
    chk("drain_start_busy", busy, 1);
    drain(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
